// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

    // Operation select, equal to funct3[1:0] of the M-extension divide group.
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_e;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam int unsigned ITER    = 32;

endpackage

// File: rtl/adder_nb.sv
// Adder with inverted b operand: sum = a + ~b + cin, i.e. a - b when cin = 1.
// cout_o is the borrow out (1 when a - b underflows with cin = 1).
module adder_nb #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] full;

    // Widened add so the carry is available; the carry is inverted into a borrow.
    always_comb begin
        full   = {1'b0, a_i} + {1'b0, ~b_i} + {{N{1'b0}}, cin_i};
        sum_o  = full[N-1:0];
        cout_o = ~full[N];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Fixed 33-cycle latency from acceptance to the done pulse, for every operand pair.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CntW = $clog2(ITER);

    div_state_e       state_q, state_d;
    div_op_e          op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] a_q, a_d;        // original dividend, returned by REM x/0
    logic [WIDTH-1:0] d_q, d_d;        // |divisor|
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             is_signed;
    logic             is_rem;
    logic             neg_want;
    logic             shift_ovf;
    logic [WIDTH-1:0] r_shift, q_shift;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_borrow;
    logic [WIDTH-1:0] fix_src;
    logic [WIDTH-1:0] neg_a_in, neg_a_out, neg_b_out;
    logic             neg_a_nz, neg_b_nz;

    // Shared datapath helpers: {R,Q} shift, result source and negation selection.
    always_comb begin
        is_signed                     = ~op[0];
        is_rem                        = (op_q == REM) || (op_q == REMU);
        {shift_ovf, r_shift, q_shift} = {r_q, q_q, 1'b0};
        fix_src                       = is_rem ? r_q : q_q;
        neg_want                      = ((op_q == DIV) && (sign_a_q ^ sign_b_q)) ||
                                        ((op_q == REM) && sign_a_q);
        // The dividend negator is reused for the final sign fix-up.
        neg_a_in                      = (state_q == FIX) ? fix_src : a;
    end

    adder_nb #(.N(WIDTH)) u_sub (
        .a_i    (r_shift),
        .b_i    (d_q),
        .cin_i  (1'b1),
        .sum_o  (sub_diff),
        .cout_o (sub_borrow)
    );

    // 0 - x; the borrow doubles as an "x is non-zero" flag.
    adder_nb #(.N(WIDTH)) u_neg_a (
        .a_i    ('0),
        .b_i    (neg_a_in),
        .cin_i  (1'b1),
        .sum_o  (neg_a_out),
        .cout_o (neg_a_nz)
    );

    adder_nb #(.N(WIDTH)) u_neg_b (
        .a_i    ('0),
        .b_i    (b),
        .cin_i  (1'b1),
        .sum_o  (neg_b_out),
        .cout_o (neg_b_nz)
    );

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        a_d        = a_q;
        d_d        = d_q;
        r_d        = r_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = div_op_e'(op);
                    sign_a_d   = is_signed & a[WIDTH-1];
                    sign_b_d   = is_signed & b[WIDTH-1];
                    div_zero_d = ~neg_b_nz;
                    ovf_d      = is_signed && (a == INT_MIN) && (b == '1);
                    a_d        = a;
                    q_d        = (is_signed & a[WIDTH-1]) ? neg_a_out : a;
                    d_d        = (is_signed & b[WIDTH-1]) ? neg_b_out : b;
                    r_d        = '0;
                    cnt_d      = '0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                // Bit shifted out of R means R' >= 2^32 > D, so the trial always fits.
                if (shift_ovf || !sub_borrow) begin
                    r_d = sub_diff;
                    q_d = {q_shift[WIDTH-1:1], 1'b1};
                end else begin
                    r_d = r_shift;
                    q_d = q_shift;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(ITER - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (div_zero_q) begin
                    result_d = is_rem ? a_q : '1;
                end else if (ovf_q) begin
                    result_d = is_rem ? '0 : INT_MIN;
                end else begin
                    // Zero needs no negation, so the non-zero flag gates the select.
                    result_d = (neg_want && neg_a_nz) ? neg_a_out : fix_src;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= DIV;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            a_q        <= '0;
            d_q        <= '0;
            r_q        <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            a_q        <= a_d;
            d_q        <= d_d;
            r_q        <= r_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed results, latency and handshake checks.
module tb_div_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next posedge (E0).
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 2'b11;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0;
    endtask

    // Counts negedges since start was raised; returns edges from E0 to the FIX edge.
    task automatic wait_done(input int from, output int lat);
        int c;
        c = from;
        while (!done && c < 100) begin
            @(negedge clk);
            c++;
        end
        lat = c - 1;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    task automatic run_vec(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp, input string tag);
        int lat;
        start_op(o, x, y);
        wait_done(1, lat);
        check_eq({tag, " latency"}, 32'(lat), 32'd33);
        check_eq(tag, result, exp);
        check_eq({tag, " busy@done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check_eq({tag, " pulse"}, 32'(done), 32'd0);
        check_eq({tag, " hold"}, result, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int nd;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset result", result, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_vec(DIVU, 32'd100, 32'd7, 32'd14, "divu 100/7");
        run_vec(REMU, 32'd100, 32'd7, 32'd2, "remu 100/7");
        run_vec(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div -7/2");
        run_vec(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem -7/2");
        run_vec(DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div 7/-2");
        run_vec(REM, 32'd7, 32'hFFFF_FFFE, 32'd1, "rem 7/-2");
        run_vec(DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, "div -100/-7");
        run_vec(REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "rem -100/-7");
        run_vec(DIVU, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, "divu 2^31/3");
        run_vec(REMU, 32'h8000_0000, 32'd3, 32'd2, "remu 2^31/3");
        run_vec(DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, "divu max/max-1");
        run_vec(REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, "remu max/16");
        run_vec(DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, "div 5/0");
        run_vec(REMU, 32'd5, 32'd0, 32'd5, "remu 5/0");
        run_vec(REM, 32'h8000_0000, 32'd0, 32'h8000_0000, "rem intmin/0");
        run_vec(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div ovf");
        run_vec(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem ovf");

        // start pulsed on cycle 5 of a busy period must be ignored
        start_op(DIVU, 32'd1000, 32'd10);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = DIVU;
        a     = 32'd9;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, lat);
        check_eq("ignored start latency", 32'(lat), 32'd33);
        check_eq("ignored start result", result, 32'd100);

        // new start in the done cycle is accepted back-to-back
        start_op(REMU, 32'd1000, 32'd7);
        wait_done(1, lat);
        check_eq("back2back latency", 32'(lat), 32'd33);
        check_eq("back2back result", result, 32'd6);
        count_dones(40, nd);
        check_eq("no extra done", 32'(nd), 32'd0);

        // reset on the 10th CALC edge discards the division
        start_op(DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid reset busy", 32'(busy), 32'd0);
        check_eq("mid reset done", 32'(done), 32'd0);
        check_eq("mid reset result", result, 32'h0);
        reset = 1'b0;
        count_dones(40, nd);
        check_eq("no done after reset", 32'(nd), 32'd0);

        run_vec(DIVU, 32'd100, 32'd7, 32'd14, "divu after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
